iff_pulse_sequencer: RTL and testbench
======================================

# iff_pulse_sequencer

Stimulus controller for paired handshake-qualified signals `a` and `b`, whose equivalence is checked by `iff`-style repetition properties elsewhere in the design. On a start request it sequences two registered pulse trains of programmable length on `a` and `b`, both rising in the same cycle. It then inserts a programmable idle gap and reports completion. An optional on-chip monitor evaluates `(a held ≥ MIN_A cycles) iff (b held ≥ MIN_B cycles)` for each train.

## Interface
- `CNT_W`, 4: width of the length, gap and run counters.
- `MIN_A`, 2: minimum `a` run length treated as "a[*MIN_A] matched".
- `MIN_B`, 3: minimum `b` run length treated as "b[*MIN_B] matched".
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `enable`  in  1  qualifies start; deassertion aborts a run in progress.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `len_a`  in  CNT_W  number of cycles `a` is held high; 0 means `a` stays low.
- `len_b`  in  CNT_W  number of cycles `b` is held high; 0 means `b` stays low.
- `gap`  in  CNT_W  idle cycles after the train, before `done`.
- `a`  out  1  registered pulse train A.
- `b`  out  1  registered pulse train B.
- `busy`  out  1  high while in RUN or GAP.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse when `enable` drops mid-run.
- `mon_valid`  out  1  verdict strobe; present only with `IFF_MON_EN`.
- `mon_pass`  out  1  verdict, valid when `mon_valid` is high; present only with `IFF_MON_EN`.

## Operation
- FSM states: IDLE, RUN, GAP.
- **IDLE → RUN:** on `start && enable`.
  - `len_a`, `len_b` and `gap` are latched on acceptance.
  - RUN length is `max(len_a, len_b)`.
  - If both lengths are 0, the FSM goes straight to GAP.
- **RUN:** `a = (cnt < len_a_q)`, `b = (cnt < len_b_q)`, where `cnt` counts up from 0.
- **RUN → GAP:** when `cnt == max − 1`. If `gap_q == 0`, RUN goes directly to IDLE.
- **GAP:** counts `gap_q` cycles, then returns to IDLE.
- **Completion:** `done` pulses in the first IDLE cycle after a normal completion.
- **Abort:** `enable == 0` in RUN or GAP.
  - Next cycle: IDLE with `a = b = busy = 0`.
  - `aborted = 1` for one cycle.
  - No `done`, no `mon_valid`.
- **Start handling:**
  - `start` while busy is ignored, with no queuing.
  - `start` with `enable = 0` is ignored.
  - `start` in the `done` cycle is accepted.
- **Width rules:**
  - Counters are CNT_W bits.
  - The max-length compare is unsigned.
  - Lengths up to 2^CNT_W − 1 are legal and do not wrap.
- **Reset:** from any state, next cycle is IDLE. All outputs are 0 (`a`, `b`, `busy`, `done`, `aborted`, `mon_valid`, `mon_pass`), counters and latched fields are 0, and a pending verdict is discarded.

## Timing
- `start` accepted at cycle T:
  - `a` is high for cycles T+1 … T+len_a.
  - `b` is high for cycles T+1 … T+len_b.
  - `busy` is high for cycles T+1 … T+max+gap.
  - `done` is high at cycle T+1+max+gap.
- Minimum start-to-start spacing: max + gap + 1 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `IFF_MON_EN`.
- **Defined:**
  - Saturating counters measure the observed consecutive high cycles of `a` and `b` during RUN.
  - `mon_valid` pulses coincident with `done`.
  - `mon_pass = ((run_a ≥ MIN_A) == (run_b ≥ MIN_B))`.
- **Undefined:** the monitor counters, `mon_valid` and `mon_pass` are absent. All other behaviour is identical.

## Structure
- Shared package `iff_seq_pkg`:
  - FSM state enum `seq_state_e` (IDLE, RUN, GAP).
  - Default `CNT_W`, `MIN_A` and `MIN_B` localparams.
- One natural sub-module, `iff_run_monitor`: the run-length counters and verdict logic, instantiated under `IFF_MON_EN`.

## Test plan
- `len_a = 2`, `len_b = 3`, `gap = 1`, start at cycle 0 → `a` high cycles 1–2, `b` high cycles 1–3, `busy` high cycles 1–4, `done` and `mon_valid` at cycle 5, `mon_pass = 1`.
- `len_a = 2`, `len_b = 2`, `gap = 0` → `done` at cycle 3, `mon_pass = 0` (a matched, b not matched).
- `len_a = 1`, `len_b = 0`, `gap = 0` → `a` high at cycle 1 only, `b` never high, `done` at cycle 2, `mon_pass = 1` (both sides false).
- `len_a = len_b = 5`, `enable` dropped at cycle 2 → `aborted` at cycle 3, `a = b = busy = 0` from cycle 3, no `done`, no `mon_valid`.
- `start` at cycle 0 with `enable = 0`, then `start` at cycle 2 while busy → first is ignored; second is ignored only if the cycle-1 accept happened. Check that exactly one train is produced per accepted start.
- `rst` asserted at cycle 2 of a `len = 4` run → from cycle 3 all outputs are 0 and the FSM is in IDLE; a new start at cycle 4 produces a full train.

Source files
------------

// File: rtl/iff_seq_pkg.sv
// rtl/iff_seq_pkg.sv - shared state enum and default parameters for the iff pulse sequencer
package iff_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } seq_state_e;

   localparam int DEF_CNT_W = 4;
   localparam int DEF_MIN_A = 2;
   localparam int DEF_MIN_B = 3;

endpackage

// File: rtl/iff_run_monitor.sv
// rtl/iff_run_monitor.sv - run-length counters and iff verdict for one a/b train
module iff_run_monitor
   import iff_seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int MIN_A = DEF_MIN_A,
   parameter int MIN_B = DEF_MIN_B
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic a_i,
   input  logic b_i,
   input  logic strobe_i,
   output logic mon_valid_o,
   output logic mon_pass_o
);

   localparam logic [CNT_W-1:0] MIN_A_C = CNT_W'(MIN_A);
   localparam logic [CNT_W-1:0] MIN_B_C = CNT_W'(MIN_B);

   logic [CNT_W-1:0] run_a_q, run_a_d, run_b_q, run_b_d;
   logic             hit_a_q, hit_a_d, hit_b_q, hit_b_d;
   logic             valid_q, pass_q, pass_d;

   // Saturating run counters; a hit is sticky until the next train starts.
   // The current sample is folded in so a run ending on the verdict cycle still counts.
   always_comb begin
      run_a_d = '0;
      run_b_d = '0;
      if (a_i) begin
         run_a_d = (clear_i || run_a_q == '1) ? (clear_i ? 1'b1 : run_a_q) : run_a_q + 1'b1;
      end
      if (b_i) begin
         run_b_d = (clear_i || run_b_q == '1) ? (clear_i ? 1'b1 : run_b_q) : run_b_q + 1'b1;
      end
      hit_a_d = (hit_a_q && !clear_i) || (a_i && run_a_d >= MIN_A_C);
      hit_b_d = (hit_b_q && !clear_i) || (b_i && run_b_d >= MIN_B_C);
      pass_d  = (hit_a_d == hit_b_d);
   end

   // Counter, hit and verdict registers; verdict is only driven while strobed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_a_q <= '0;
         run_b_q <= '0;
         hit_a_q <= 1'b0;
         hit_b_q <= 1'b0;
         valid_q <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         run_a_q <= run_a_d;
         run_b_q <= run_b_d;
         hit_a_q <= hit_a_d;
         hit_b_q <= hit_b_d;
         valid_q <= strobe_i;
         pass_q  <= strobe_i && pass_d;
      end
   end

   assign mon_valid_o = valid_q;
   assign mon_pass_o  = pass_q;

endmodule

// File: rtl/iff_pulse_sequencer.sv
// rtl/iff_pulse_sequencer.sv - paired a/b pulse train sequencer with gap and optional monitor (IFF_MON_EN)
module iff_pulse_sequencer
   import iff_seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
`ifdef IFF_MON_EN
   ,
   parameter int MIN_A = DEF_MIN_A,
   parameter int MIN_B = DEF_MIN_B
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic [CNT_W-1:0] len_a,
   input  logic [CNT_W-1:0] len_b,
   input  logic [CNT_W-1:0] gap,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             aborted
`ifdef IFF_MON_EN
   ,
   output logic             mon_valid,
   output logic             mon_pass
`endif
);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_a_q, len_a_d, len_b_q, len_b_d, gap_q, gap_d;
   logic             a_q, a_d, b_q, b_d, busy_q, busy_d;
   logic             done_q, done_d, aborted_q, aborted_d;
   logic             accept;

   function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
      return (x > y) ? x : y;
   endfunction

   assign accept = (state_q == IDLE) && start && enable;

   // Next-state logic; outputs are derived from the next state so they can be registered.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_a_d   = len_a_q;
      len_b_d   = len_b_q;
      gap_d     = gap_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               len_a_d = len_a;
               len_b_d = len_b;
               gap_d   = gap;
               cnt_d   = '0;
               if (umax(len_a, len_b) != '0) begin
                  state_d = RUN;
               end else if (gap != '0) begin
                  state_d = GAP;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (!enable) begin
               state_d   = IDLE;
               cnt_d     = '0;
               aborted_d = 1'b1;
            end else if (cnt_q == umax(len_a_q, len_b_q) - 1'b1) begin
               cnt_d = '0;
               if (gap_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = GAP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (!enable) begin
               state_d   = IDLE;
               cnt_d     = '0;
               aborted_d = 1'b1;
            end else if (cnt_q == gap_q - 1'b1) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      a_d    = (state_d == RUN) && (cnt_d < len_a_d);
      b_d    = (state_d == RUN) && (cnt_d < len_b_d);
      busy_d = (state_d != IDLE);
   end

   // State, latched fields and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_a_q   <= '0;
         len_b_q   <= '0;
         gap_q     <= '0;
         a_q       <= 1'b0;
         b_q       <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_a_q   <= len_a_d;
         len_b_q   <= len_b_d;
         gap_q     <= gap_d;
         a_q       <= a_d;
         b_q       <= b_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign a       = a_q;
   assign b       = b_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = aborted_q;

`ifdef IFF_MON_EN
   iff_run_monitor #(
      .CNT_W(CNT_W),
      .MIN_A(MIN_A),
      .MIN_B(MIN_B)
   ) u_mon (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (accept),
      .a_i        (a_q),
      .b_i        (b_q),
      .strobe_i   (done_d),
      .mon_valid_o(mon_valid),
      .mon_pass_o (mon_pass)
   );
`endif

endmodule

// File: tb/tb_iff_pulse_sequencer.sv
// tb/tb_iff_pulse_sequencer.sv - table-driven self-checking bench for iff_pulse_sequencer
module tb_iff_pulse_sequencer;

   typedef struct {
      bit       rst;
      bit       en;
      bit       st;
      bit [3:0] la;
      bit [3:0] lb;
      bit [3:0] g;
      bit       ea;
      bit       eb;
      bit       ebusy;
      bit       edone;
      bit       eab;
      bit       emv;
      bit       emp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, enable, start;
   logic [3:0] len_a, len_b, gap;
   logic       a, b, busy, done, aborted;
`ifdef IFF_MON_EN
   logic       mon_valid, mon_pass;
`endif

   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   iff_pulse_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .start    (start),
      .len_a    (len_a),
      .len_b    (len_b),
      .gap      (gap),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .aborted  (aborted)
`ifdef IFF_MON_EN
      ,
      .mon_valid(mon_valid),
      .mon_pass (mon_pass)
`endif
   );

   task automatic chk(input string name, input int idx, input logic got, input bit want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s step %0d: got %b want %b", name, idx, got, want);
      end
   endtask

   task automatic check_all(input int idx, input bit ea, eb, ebusy, edone, eab, emv, emp);
      chk("a", idx, a, ea);
      chk("b", idx, b, eb);
      chk("busy", idx, busy, ebusy);
      chk("done", idx, done, edone);
      chk("aborted", idx, aborted, eab);
`ifdef IFF_MON_EN
      chk("mon_valid", idx, mon_valid, emv);
      chk("mon_pass", idx, mon_pass, emp);
`else
      if (emv || emp) begin
      end
`endif
   endtask

   task automatic v(input bit r, en, st, input int la, lb, g,
                    input bit ea, eb, ebusy, edone, eab, emv, emp);
      vec_t t;
      t.rst = r; t.en = en; t.st = st;
      t.la = 4'(la); t.lb = 4'(lb); t.g = 4'(g);
      t.ea = ea; t.eb = eb; t.ebusy = ebusy; t.edone = edone;
      t.eab = eab; t.emv = emv; t.emp = emp;
      vecs.push_back(t);
   endtask

   task automatic drive(input bit r, en, st, input int la, lb, g);
      rst = r; enable = en; start = st;
      len_a = 4'(la); len_b = 4'(lb); gap = 4'(g);
   endtask

   initial begin
      //     rst en st la lb g    a b busy done ab mv mp
      v(0, 1, 1, 2, 3, 1,   0, 0, 0, 0, 0, 0, 0);  // 0: start 2/3/1
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);  // gap cycle
      v(0, 1, 1, 2, 2, 0,   0, 0, 0, 1, 0, 1, 1);  // 5: done; start in done cycle
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 1, 1, 0, 0,   0, 0, 0, 1, 0, 1, 0);  // 8: b not matched; start 1/0/0
      v(0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0);
      v(0, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 1, 1);  // 10: both false; start 0/0/0
      v(0, 1, 1, 0, 0, 2,   0, 0, 0, 1, 0, 1, 1);  // 11: empty train done; start 0/0/2
      v(0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
      v(0, 1, 1, 5, 5, 0,   0, 0, 0, 1, 0, 1, 1);  // 14: start 5/5/0
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);  // 16: enable dropped
      v(0, 0, 1, 5, 5, 0,   0, 0, 0, 0, 1, 0, 0);  // 17: aborted; start with enable low
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      v(0, 1, 1, 2, 2, 1,   0, 0, 0, 0, 0, 0, 0);  // 19: start 2/2/1
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 1, 4, 4, 0,   1, 1, 1, 0, 0, 0, 0);  // 21: start while busy
      v(0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 0);
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);  // no second train
      v(0, 1, 1, 4, 4, 0,   0, 0, 0, 0, 0, 0, 0);  // 25: start 4/4/0
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(1, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);  // 27: reset mid-run
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      v(0, 1, 1, 4, 4, 0,   0, 0, 0, 0, 0, 0, 0);  // 29: fresh start 4/4/0
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 1);
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      v(0, 1, 1, 1, 0, 3,   0, 0, 0, 0, 0, 0, 0);  // 36: start 1/0/3
      v(0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);  // 38: abort in GAP
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);

      drive(1, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_all(-1, 0, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].st, int'(vecs[i].la), int'(vecs[i].lb), int'(vecs[i].g));
         check_all(i, vecs[i].ea, vecs[i].eb, vecs[i].ebusy, vecs[i].edone,
                   vecs[i].eab, vecs[i].emv, vecs[i].emp);
         @(posedge clk);
         #1;
      end

      // Longest legal lengths: a for 15 cycles, then 15 gap cycles, done at T+31.
      drive(0, 1, 1, 15, 1, 15);
      check_all(100, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      drive(0, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 34; k++) begin
         check_all(100 + k, k <= 15, k <= 1, k <= 30, k == 31, 1'b0, k == 31, 1'b0);
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
